noobs_mem_arb: RTL
==================

NOOBS_MEM_ARB -- requirements
Module: noobs_mem_arb

Interface
REQ-001 Port list, in order:
- clk, input, 1: sole clock; all state changes on its rising edge.
- reset, input, 1: synchronous active-high reset.
- i_req, input, 1: instruction fetch request; held until i_gnt.
- i_addr, input, 12: fetch address.
- i_gnt, output, 1: one-cycle pulse; fetch request accepted.
- i_rvld, output, 1: one-cycle pulse; i_rdata valid.
- i_rdata, output, 8: fetched byte.
- d_en, input, 1: data request qualifier.
- d_rd, input, 1: data read request.
- d_wr, input, 1: data write request.
- d_addr, input, 12: data address.
- d_wdata, input, 8: data write byte.
- d_gnt, output, 1: one-cycle pulse; data request accepted.
- d_rvld, output, 1: one-cycle pulse; d_rdata valid.
- d_rdata, output, 8: data read byte.
- d_err, output, 1: one-cycle pulse; illegal request dropped.
- mem_en, output, 1: shared single-port memory enable.
- mem_wr, output, 1: memory write strobe.
- mem_addr, output, 12: memory address.
- mem_wdata, output, 8: memory write byte.
- mem_rdata, input, 8: memory read byte, valid the cycle after mem_en with mem_wr low.

REQ-002 The block SHALL use one clock; reset SHALL be synchronous and active-high.

Function
REQ-003 The block SHALL share one single-port 4 KB memory between the fetch requester and the data requester, one transaction at a time.
REQ-004 The FSM SHALL have three states:
- IDLE: arbitrates.
- ISSUE: drives the memory for exactly one cycle.
- RESP: captures read data.
REQ-005 IDLE behaviour:
- A pending request selects a winner, latches its address, write data and type, pulses that requester's gnt, and moves to ISSUE.
- With no request, the FSM stays in IDLE.
REQ-006 In ISSUE the block SHALL assert mem_en with the latched address, data and mem_wr. A read SHALL go to RESP; a write SHALL go to IDLE.
REQ-007 In RESP the block SHALL register mem_rdata into the winner's rdata, pulse the winner's rvld, and return to IDLE.
REQ-008 Latency SHALL be request to gnt 1 cycle, gnt to mem_en 1 cycle, and mem_en to rvld 2 cycles. A new grant SHALL NOT occur before returning to IDLE.
REQ-009 i_rdata and d_rdata SHALL hold their last value until the next read completes for that port.
REQ-010 A data request is pending when d_en=1 and exactly one of d_rd or d_wr is 1.
REQ-011 d_en=1 with d_rd=d_wr=1 SHALL pulse d_err in IDLE, grant nothing, and never reach the memory.
REQ-012 d_en=1 with d_rd=d_wr=0 SHALL be ignored.
REQ-013 Request inputs SHALL be sampled only in IDLE; changes in ISSUE or RESP SHALL NOT affect the transaction in flight.
REQ-014 mem_en, mem_wr and all gnt, rvld and err pulses SHALL be 0 in every cycle not named above.

Reset
REQ-015 Reset SHALL force:
- FSM to IDLE;
- all outputs and rdata registers to 0;
- round-robin pointer to favour data.
REQ-016 Reset during ISSUE or RESP SHALL abort the transaction: no rvld, no further mem_en, and request state discarded.

Configuration
REQ-017 With NOOBS_MEM_ARB_RR_EN defined:
- Simultaneous requests SHALL alternate via a 1-bit pointer.
- The pointer SHALL point away from the last winner after each grant.
REQ-018 Without NOOBS_MEM_ARB_RR_EN:
- Data SHALL have fixed priority over fetch.
- The pointer logic SHALL be absent.

Structure
REQ-019 Package noobs_mem_pkg SHALL hold:
- FSM state encoding (IDLE, ISSUE, RESP);
- requester IDs (REQ_FETCH, REQ_DATA);
- address and data width constants (12, 8).
REQ-020 The winner selection SHALL be a sub-module, noobs_rr_arb2, a two-way arbiter whose pointer exists only under NOOBS_MEM_ARB_RR_EN.

Verification
REQ-021 Lone fetch read:
- Stimulus: i_req, addr 0x010, memory holds 0xA5.
- Response: i_gnt at T+1, mem_en at T+2, i_rvld=1 with i_rdata=0xA5 at T+4.
REQ-022 Data write then read:
- Stimulus: write 0x3C to 0xFFF, then read 0xFFF.
- Response: mem_wr for one cycle; d_rdata=0x3C with d_rvld.
REQ-023 Simultaneous requests, held continuously:
- With RR: grants alternate D, I, D, I.
- Without RR: every grant goes to data.
REQ-024 Illegal data request:
- Stimulus: d_en=d_rd=d_wr=1.
- Response: d_err pulses once; mem_en stays 0; no gnt.
REQ-025 Reset mid-transaction:
- Stimulus: reset asserted in RESP.
- Response: no rvld; all outputs 0 next cycle; FSM in IDLE.

Source files
------------

// File: rtl/noobs_mem_pkg.sv
// Shared types and constants for the noobs_mem_arb memory arbiter.
// Build option: NOOBS_MEM_ARB_RR_EN selects round-robin arbitration.
package noobs_mem_pkg;

    localparam int ADDR_W = 12;
    localparam int DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    typedef enum logic {
        REQ_FETCH = 1'b0,
        REQ_DATA  = 1'b1
    } req_id_t;

    // The requester that is not `id`
    function automatic req_id_t other_req(input req_id_t id);
        return (id == REQ_DATA) ? REQ_FETCH : REQ_DATA;
    endfunction

endpackage

// File: rtl/noobs_mem_arb_if.sv
// Shared single-port memory bus as seen from the arbiter (master)
// and from the memory (slave).
interface noobs_mem_arb_if
    import noobs_mem_pkg::*;
;
    logic              mem_en;
    logic              mem_wr;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output mem_en, mem_wr, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport slave (
        input  mem_en, mem_wr, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/noobs_rr_arb2.sv
// Two-way winner selection between fetch and data requesters.
// With NOOBS_MEM_ARB_RR_EN a 1-bit pointer alternates simultaneous
// requests; without it data has fixed priority and no pointer exists.
module noobs_rr_arb2
    import noobs_mem_pkg::*;
(
`ifdef NOOBS_MEM_ARB_RR_EN
    input  logic    clk,
    input  logic    reset,
    input  logic    i_advance,
`endif
    input  logic    i_req_fetch,
    input  logic    i_req_data,
    output logic    o_valid,
    output req_id_t o_winner
);

    assign o_valid = i_req_fetch | i_req_data;

`ifdef NOOBS_MEM_ARB_RR_EN
    req_id_t r_ptr;

    // Pointer moves away from the requester that just won
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values
        if (reset) begin
            r_ptr <= REQ_DATA;
        end else if (i_advance) begin
            r_ptr <= other_req(o_winner);
        end
    end

    // Lone requester wins outright; a tie goes to the favoured side
    always_comb begin
        // NOTE: default assignment first so no path leaves o_winner unassigned (no latch)
        o_winner = r_ptr;
        if (!i_req_data) begin
            o_winner = REQ_FETCH;
        end else if (!i_req_fetch) begin
            o_winner = REQ_DATA;
        end
    end
`else
    // Data beats fetch whenever both ask
    always_comb begin
        o_winner = REQ_DATA;
        if (!i_req_data) begin
            o_winner = REQ_FETCH;
        end
    end
`endif

endmodule

// File: rtl/noobs_mem_arb.sv
// Arbiter sharing one single-port 4 KB memory between an instruction
// fetch port and a data port, one transaction at a time.
// Build option: NOOBS_MEM_ARB_RR_EN (round-robin instead of data priority).
module noobs_mem_arb
    import noobs_mem_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_gnt,
    output logic              i_rvld,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_en,
    input  logic              d_rd,
    input  logic              d_wr,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvld,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_err,
    output logic              mem_en,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    state_t            r_state;
    req_id_t           r_winner;
    logic              r_is_wr;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic              r_i_gnt, r_i_rvld, r_d_gnt, r_d_rvld, r_d_err;
    logic              r_mem_en, r_mem_wr;
    logic [DATA_W-1:0] r_i_rdata, r_d_rdata;

    logic              w_d_pend;
    logic              w_d_illegal;
    logic              w_arb_valid;
    req_id_t           w_arb_winner;

    // A data request is legal only with exactly one of rd/wr set
    assign w_d_pend    = d_en & (d_rd ^ d_wr);
    assign w_d_illegal = d_en & d_rd & d_wr;

    noobs_rr_arb2 u_arb (
`ifdef NOOBS_MEM_ARB_RR_EN
        .clk         (clk),
        .reset       (reset),
        .i_advance   ((r_state == IDLE) && w_arb_valid),
`endif
        .i_req_fetch (i_req),
        .i_req_data  (w_d_pend),
        .o_valid     (w_arb_valid),
        .o_winner    (w_arb_winner)
    );

    // Transaction FSM: arbitrate, drive memory once, collect read data
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: the latched request and rdata registers are cleared too, so an aborted transaction leaves nothing behind
            r_state   <= IDLE;
            r_winner  <= REQ_DATA;
            r_is_wr   <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_i_gnt   <= 1'b0;
            r_i_rvld  <= 1'b0;
            r_d_gnt   <= 1'b0;
            r_d_rvld  <= 1'b0;
            r_d_err   <= 1'b0;
            r_mem_en  <= 1'b0;
            r_mem_wr  <= 1'b0;
            r_i_rdata <= '0;
            r_d_rdata <= '0;
        end else begin
            r_i_gnt  <= 1'b0;
            r_i_rvld <= 1'b0;
            r_d_gnt  <= 1'b0;
            r_d_rvld <= 1'b0;
            r_d_err  <= 1'b0;
            r_mem_en <= 1'b0;
            r_mem_wr <= 1'b0;
            case (r_state)
                IDLE: begin
                    // An illegal data request is reported and dropped; it
                    // is simply not pending, so a fetch may still be served.
                    r_d_err <= w_d_illegal;
                    if (w_arb_valid) begin
                        r_winner <= w_arb_winner;
                        if (w_arb_winner == REQ_DATA) begin
                            r_addr  <= d_addr;
                            r_wdata <= d_wdata;
                            r_is_wr <= d_wr;
                            r_d_gnt <= 1'b1;
                        end else begin
                            r_addr  <= i_addr;
                            r_wdata <= '0;
                            r_is_wr <= 1'b0;
                            r_i_gnt <= 1'b1;
                        end
                        r_state <= ISSUE;
                    end
                end
                ISSUE: begin
                    r_mem_en <= 1'b1;
                    r_mem_wr <= r_is_wr;
                    r_state  <= r_is_wr ? IDLE : RESP;
                end
                RESP: begin
                    // First RESP cycle is the memory access itself; the
                    // byte appears on mem_rdata the cycle after.
                    if (!r_mem_en) begin
                        if (r_winner == REQ_DATA) begin
                            r_d_rdata <= mem_rdata;
                            r_d_rvld  <= 1'b1;
                        end else begin
                            r_i_rdata <= mem_rdata;
                            r_i_rvld  <= 1'b1;
                        end
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign i_gnt     = r_i_gnt;
    assign i_rvld    = r_i_rvld;
    assign i_rdata   = r_i_rdata;
    assign d_gnt     = r_d_gnt;
    assign d_rvld    = r_d_rvld;
    assign d_rdata   = r_d_rdata;
    assign d_err     = r_d_err;
    assign mem_en    = r_mem_en;
    assign mem_wr    = r_mem_wr;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;

endmodule
